// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 max pooling over binary32 feature maps in raster order.
// Top-row pair maxima are parked in a half-width line buffer until the bottom row arrives.
module max_pool_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int FILTERS    = 64,
    parameter int INPUT      = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_map_last,
    output logic                  m_frame_last
);
    localparam int HALF = INPUT / 2;
    localparam int CW   = $clog2(INPUT);
    localparam int FW   = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] COL_MAX  = CW'(INPUT - 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTERS - 1);

    // Sign-magnitude compare; bit-identical operands return a.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        r = a;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            r = a[DATA_WIDTH-1] ? b : a;
        end else if (!a[DATA_WIDTH-1]) begin
            if (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) r = b;
        end else begin
            if (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) r = b;
        end
        return r;
    endfunction

    logic [CW-1:0]         col_q, col_d, row_q, row_d;
    logic [FW-1:0]         filt_q, filt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  map_last_q, map_last_d;
    logic                  frame_last_q, frame_last_d;

    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] lb_rd_q;
    logic [DATA_WIDTH-1:0] line_buf [HALF];

    logic                  accept, col_last, row_last, filt_last, win_done;
    logic [LW-1:0]         lb_addr;
    logic [DATA_WIDTH-1:0] h_max, v_max;

    assign s_ready   = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign col_last  = (col_q == COL_MAX);
    assign row_last  = (row_q == COL_MAX);
    assign filt_last = (filt_q == FILT_MAX);
    assign win_done  = accept && col_q[0] && row_q[0];
    assign lb_addr   = LW'(col_q >> 1);
    assign h_max     = fmax(hold_q, s_data);
    assign v_max     = fmax(lb_rd_q, h_max);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        filt_d = filt_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    filt_d = filt_last ? '0 : filt_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A completing window takes priority over a drain, so back-to-back outputs never bubble.
    always_comb begin
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        map_last_d   = map_last_q;
        frame_last_d = frame_last_q;
        if (win_done) begin
            m_data_d     = v_max;
            m_valid_d    = 1'b1;
            map_last_d   = col_last && row_last;
            frame_last_d = col_last && row_last && filt_last;
        end else if (m_valid_q && m_ready) begin
            m_valid_d    = 1'b0;
            map_last_d   = 1'b0;
            frame_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            filt_q       <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            map_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            filt_q       <= filt_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            map_last_q   <= map_last_d;
            frame_last_q <= frame_last_d;
        end
    end

    // The read address is fixed across an even/odd column pair, so the registered read
    // taken while the even element is in flight is ready for the odd one.
    always_ff @(posedge clk) begin
        if (accept && !col_q[0]) hold_q <= s_data;
        if (accept && col_q[0] && !row_q[0]) line_buf[lb_addr] <= h_max;
        lb_rd_q <= line_buf[lb_addr];
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_map_last   = map_last_q;
    assign m_frame_last = frame_last_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: four instances (4x4/1, 2x2/1, 4x4/3, 30x30/64) sharing clock and reset.
module tb_max_pool_stream;
    typedef struct {
        logic [31:0] d;
        logic        ml;
        logic        mf;
    } beat_t;

    typedef struct {
        logic [31:0] in0, in1, in2, in3;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int DN = 30;
    localparam int DF = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sd [4];
    logic        sv [4];
    logic        sr [4];
    logic [31:0] md [4];
    logic        mv [4];
    logic        mr [4];
    logic        ml [4];
    logic        mf [4];

    int checks = 0;
    int errors = 0;
    beat_t qa[$], qb[$], qc[$], qd[$], exp_d[$];
    logic [31:0] img [DN][DN];
    bit d_done;

    always #5 clk = ~clk;

    max_pool_stream #(.DATA_WIDTH(32), .FILTERS(1), .INPUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(sr[0]),
        .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_map_last(ml[0]), .m_frame_last(mf[0]));
    max_pool_stream #(.DATA_WIDTH(32), .FILTERS(1), .INPUT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(sr[1]),
        .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_map_last(ml[1]), .m_frame_last(mf[1]));
    max_pool_stream #(.DATA_WIDTH(32), .FILTERS(3), .INPUT(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_data(sd[2]), .s_valid(sv[2]), .s_ready(sr[2]),
        .m_data(md[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_map_last(ml[2]), .m_frame_last(mf[2]));
    max_pool_stream #(.DATA_WIDTH(32), .FILTERS(DF), .INPUT(DN)) dut_d (
        .clk(clk), .rst_n(rst_n), .s_data(sd[3]), .s_valid(sv[3]), .s_ready(sr[3]),
        .m_data(md[3]), .m_valid(mv[3]), .m_ready(mr[3]), .m_map_last(ml[3]), .m_frame_last(mf[3]));

    function automatic beat_t mk(logic [31:0] d, logic l, logic f);
        beat_t b;
        b.d = d;
        b.ml = l;
        b.mf = f;
        return b;
    endfunction

    // Outputs are sampled mid-cycle; a beat counts when it will transfer on the next edge.
    always @(negedge clk) begin
        if (mv[0] && mr[0]) qa.push_back(mk(md[0], ml[0], mf[0]));
        if (mv[1] && mr[1]) qb.push_back(mk(md[1], ml[1], mf[1]));
        if (mv[2] && mr[2]) qc.push_back(mk(md[2], ml[2], mf[2]));
        if (mv[3] && mr[3]) qd.push_back(mk(md[3], ml[3], mf[3]));
    end

    // Small non-negative integer to binary32.
    function automatic logic [31:0] i2f(int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (((n >> i) & 1) == 1) p = i;
        m = 32'(n << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Monotonic key: the larger key is the value the pooling order prefers.
    function automatic logic [31:0] fkey(logic [31:0] x);
        return x[31] ? (32'h7FFF_FFFF - {1'b0, x[30:0]}) : (32'h8000_0000 + {1'b0, x[30:0]});
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return qa.size();
            1: return qb.size();
            2: return qc.size();
            default: return qd.size();
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic chk_quiet(string name, int idx, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, expv);
        end
    endtask

    task automatic send(int k, logic [31:0] v, bit gaps);
        int n;
        n = 0;
        if (gaps && ($urandom % 20) == 0) begin
            sv[k] = 1'b0;
            @(posedge clk);
            #1;
        end
        sd[k] = v;
        sv[k] = 1'b1;
        @(negedge clk);
        while (!sr[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!sr[k]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst %0d: s_ready got 0 expected 1", k);
        end
        @(posedge clk);
        #1;
        sv[k] = 1'b0;
    endtask

    task automatic wait_q(int k, int n, int lim);
        int t;
        t = 0;
        while (qsize(k) < n && t < lim) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_ramp_q(string name);
        int w [4] = '{5, 7, 13, 15};
        chk({name, "_count"}, 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            chk_quiet({name, "_data"}, i, qa[i].d, i2f(w[i]));
            chk_quiet({name, "_last"}, i, {30'd0, qa[i].mf, qa[i].ml}, (i == 3) ? 32'd3 : 32'd0);
        end
    endtask

    initial begin
        vec_t vt [5];
        int  mid;
        vt[0] = '{32'hC040_0000, 32'hBFC0_0000, 32'hC000_0000, 32'hC0E0_0000, 32'hBFC0_0000, "neg"};
        vt[1] = '{32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000, "zeros"};
        vt[2] = '{32'h4020_0000, 32'h4020_0000, 32'h4020_0000, 32'h4020_0000, 32'h4020_0000, "ident"};
        vt[3] = '{32'h3F80_0000, 32'hC0A0_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4040_0000, "mixed"};
        vt[4] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000, "nan"};

        for (int k = 0; k < 4; k++) begin
            sd[k] = '0;
            sv[k] = 1'b0;
            mr[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k += 3) begin
            chk("reset_m_valid", {31'd0, mv[k]}, 32'd0);
            chk("reset_m_data", md[k], 32'd0);
            chk("reset_lasts", {30'd0, mf[k], ml[k]}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("reset_s_ready", {31'd0, sr[0]}, 32'd1);

        // Ramp with output visible one cycle after each window's last element.
        qa.delete();
        for (int i = 0; i < 16; i++) begin
            send(0, i2f(i), 1'b0);
            if (i == 5 || i == 7 || i == 13 || i == 15) begin
                chk("ramp_latency_valid", {31'd0, mv[0]}, 32'd1);
                chk("ramp_latency_data", md[0], i2f(i));
                chk("ramp_latency_lasts", {30'd0, mf[0], ml[0]}, (i == 15) ? 32'd3 : 32'd0);
            end
            if (i == 6) chk("ramp_drained", {31'd0, mv[0]}, 32'd0);
        end
        wait_q(0, 4, 50);
        check_ramp_q("ramp");

        // Backpressure: output held while m_ready is low.
        qa.delete();
        mr[0] = 1'b0;
        for (int i = 0; i < 6; i++) send(0, i2f(i), 1'b0);
        chk("bp_s_ready_drop", {31'd0, sr[0]}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", md[0], i2f(5));
            chk("bp_hold_valid", {31'd0, mv[0]}, 32'd1);
        end
        mr[0] = 1'b1;
        for (int i = 6; i < 16; i++) send(0, i2f(i), 1'b0);
        wait_q(0, 4, 50);
        check_ramp_q("bp");

        // Asynchronous reset mid-map.
        for (int i = 0; i < 6; i++) send(0, i2f(i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, mv[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        for (int i = 0; i < 16; i++) send(0, i2f(i), 1'b1);
        wait_q(0, 4, 50);
        check_ramp_q("post_rst");

        // Table-driven sign / special-value windows on the 2x2 instance.
        for (int t = 0; t < 5; t++) begin
            qb.delete();
            send(1, vt[t].in0, 1'b0);
            send(1, vt[t].in1, 1'b0);
            send(1, vt[t].in2, 1'b0);
            send(1, vt[t].in3, 1'b0);
            wait_q(1, 1, 20);
            chk({"signs_count_", vt[t].name}, 32'(qb.size()), 32'd1);
            if (qb.size() > 0) begin
                chk({"signs_data_", vt[t].name}, qb[0].d, vt[t].exp);
                chk({"signs_lasts_", vt[t].name}, {30'd0, qb[0].mf, qb[0].ml}, 32'd3);
            end
        end

        // Two back-to-back frames of three maps.
        qc.delete();
        for (int fr = 0; fr < 2; fr++)
            for (int f = 0; f < 3; f++)
                for (int i = 0; i < 16; i++) send(2, i2f(100 * f + i), 1'b1);
        wait_q(2, 24, 100);
        chk("multi_count", 32'(qc.size()), 32'd24);
        begin
            int w [4] = '{5, 7, 13, 15};
            for (int n = 0; n < 24 && n < qc.size(); n++) begin
                chk_quiet("multi_data", n, qc[n].d, i2f(100 * ((n / 4) % 3) + w[n % 4]));
                chk_quiet("multi_lasts", n, {30'd0, qc[n].mf, qc[n].ml},
                          (n % 4 != 3) ? 32'd0 : ((n % 12 == 11) ? 32'd3 : 32'd1));
            end
        end

        // Full-size random frame against the reference model.
        qd.delete();
        exp_d.delete();
        d_done = 1'b0;
        fork
            begin
                for (int f = 0; f < DF; f++) begin
                    for (int r = 0; r < DN; r++)
                        for (int c = 0; c < DN; c++) begin
                            img[r][c] = $urandom;
                            send(3, img[r][c], 1'b1);
                        end
                    for (int r2 = 0; r2 < DN / 2; r2++)
                        for (int c2 = 0; c2 < DN / 2; c2++) begin
                            logic [31:0] best;
                            best = img[2 * r2][2 * c2];
                            for (int dr = 0; dr < 2; dr++)
                                for (int dc = 0; dc < 2; dc++)
                                    if (fkey(img[2 * r2 + dr][2 * c2 + dc]) > fkey(best))
                                        best = img[2 * r2 + dr][2 * c2 + dc];
                            mid = (r2 == DN / 2 - 1 && c2 == DN / 2 - 1) ? 1 : 0;
                            exp_d.push_back(mk(best, mid == 1, mid == 1 && f == DF - 1));
                        end
                end
                d_done = 1'b1;
            end
            begin
                while (!d_done) begin
                    @(posedge clk);
                    #1;
                    mr[3] = ($urandom % 5) != 0;
                end
                mr[3] = 1'b1;
            end
        join
        wait_q(3, exp_d.size(), 200);
        chk("rand_count", 32'(qd.size()), 32'd14400);
        for (int n = 0; n < exp_d.size() && n < qd.size(); n++) begin
            chk_quiet("rand_data", n, qd[n].d, exp_d[n].d);
            chk_quiet("rand_lasts", n, {30'd0, qd[n].mf, qd[n].ml}, {30'd0, exp_d[n].mf, exp_d[n].ml});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the batch-normalization layer.
- Consumes BN output one IEEE-754 single-precision element per beat, in raster order: column fastest, then row, then filter map.
- Emits the pooled map of (INPUT/2) x (INPUT/2) elements per filter, in the same order.
- Uses a half-width line buffer of partial maxima, so a full map is never stored.

Parameters:
- DATA_WIDTH, 32: element width; IEEE-754 binary32. Only 32 is supported.
- FILTERS, 64: number of feature maps per frame.
- INPUT, 30: map height and width. Must be even and >= 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  DATA_WIDTH  input element (binary32).
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block accepts s_data this cycle.
- m_data  out  DATA_WIDTH  pooled element.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts m_data.
- m_map_last  out  1  qualifies the beat with m_valid; marks the last pooled element of a map.
- m_frame_last  out  1  qualifies the beat with m_valid; marks the last pooled element of the last map.

Behaviour:
- Reset: rst_n low asynchronously clears all registers.
  - col, row and filt counters go to 0.
  - Hold and line-buffer contents are don't-care; they are overwritten before use.
  - m_valid=0, m_map_last=0, m_frame_last=0, m_data=0.
  - s_ready=1 after reset.
- Handshake:
  - An input beat is accepted when s_valid && s_ready.
  - An output beat is transferred when m_valid && m_ready.
  - m_data, m_valid, m_map_last and m_frame_last stay stable while m_valid && !m_ready.
  - s_ready = !m_valid || m_ready (combinational).
- Counters advance only on accepted beats.
  - col wraps INPUT-1 -> 0 and increments row.
  - row wraps INPUT-1 -> 0 and increments filt.
  - filt wraps FILTERS-1 -> 0. The next frame starts with no idle cycle.
- Datapath, per accepted beat:
  - Even col: store s_data in the hold register.
  - Odd col, even row: h = fmax(hold, s_data); write h to line_buf[col>>1].
  - Odd col, odd row: v = fmax(line_buf[col>>1], fmax(hold, s_data)); register v into m_data and set m_valid=1 on the next edge.
  - Latency: 1 cycle from accepting the bottom-right element of a window to m_valid.
  - m_map_last=1 when row==INPUT-1 and col==INPUT-1.
  - m_frame_last=1 additionally requires filt==FILTERS-1.
- Simultaneous events:
  - When an output is drained in the same cycle a new window completes, m_valid stays 1 and m_data updates. No bubble and no loss.
  - m_valid clears only on a transfer with no new window completing.
- fmax(a,b) is a pure bitwise compare, with no FP unit:
  - Signs differ: the non-negative operand wins, so +0 beats -0.
  - Both positive: larger magnitude bits [30:0] wins.
  - Both negative: smaller magnitude wins.
  - Bit-identical operands: result is a.
  - NaN and denormal inputs are compared as ordinary bit patterns; no special handling.
- Line buffer: INPUT/2 entries x DATA_WIDTH; one write per even-row pair, one read per odd-row pair.
- Throughput: 1 input per cycle when m_ready is held high. Output rate is 1/4 of input.
- Reset mid-frame discards the partial map. Post-reset input is treated as element (0,0) of filter 0.

Test Plan:
- Ramp, INPUT=4, FILTERS=1: input value = row*4+col as floats 0.0..15.0, m_ready=1.
  - m_data = 5.0, 7.0, 13.0, 15.0.
  - m_map_last and m_frame_last only on the 15.0 beat.
  - Each output 1 cycle after accepting elements 5, 7, 13, 15.
- Signs, INPUT=2: {-3.0, -1.5, -2.0, -7.0} -> -1.5.
  - {-0.0, +0.0, -1.0, -2.0} -> 0x00000000.
  - Identical inputs 2.5 x4 -> 2.5.
- Backpressure: ramp with m_ready=0 for 5 cycles after the first m_valid.
  - s_ready drops the cycle after the first window completes.
  - m_data is held at 5.0.
  - Stream resumes with no loss or duplication; total outputs = 4.
- Multi-map, INPUT=4, FILTERS=3: filter f adds 100*f to the ramp.
  - Outputs {5,7,13,15}, {105,107,113,115}, {205,207,213,215}.
  - m_map_last three times; m_frame_last once, on 215.0.
  - A second frame back-to-back repeats identically.
- Reset mid-op: assert rst_n=0 after 6 accepted beats.
  - m_valid=0 immediately (asynchronous).
  - A full ramp after release yields 5.0, 7.0, 13.0, 15.0.
- Default params, INPUT=30, FILTERS=64: random values from a reference model, random s_valid/m_ready.
  - Exactly 14400 outputs, matching the model bit-exactly.
